// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port arbiter.
// Both requesters hold xx_req and their fields stable until a cycle with xx_gnt = 1;
// that cycle's clock edge completes the handshake, and one xx_rvalid pulse follows later.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [63:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    logic              busy;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requester / memory / environment view.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported byte memory between instruction fetch
// and load/store; one access at a time, fixed MEM_LAT access cycles, registered response.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int MEM_LAT = 1   // legal range 1..15
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]        dbg_state
);
    localparam int CNT_W = 4;
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [63:0]       mem_wdata_q;
    logic              if_rvalid_q;
    logic              d_rvalid_q;
    logic [31:0]       if_rdata_q;
    logic [63:0]       d_rdata_q;
    logic              busy_q;

    logic              pick_data;
    logic              can_grant;
    logic              if_gnt_c;
    logic              d_gnt_c;

    // Data wins a tie only when fetch was served last; reset is gated in so no grant
    // can be seen while the block is held in reset.
    always_comb begin
        pick_data = bus.d_req && (!bus.if_req || (last_grant == OWN_FETCH));
        can_grant = (state == IDLE) && !reset;
        if_gnt_c  = can_grant && bus.if_req && !pick_data;
        d_gnt_c   = can_grant && pick_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_FETCH;
            last_grant  <= OWN_DATA;
            cnt         <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_gnt_c || d_gnt_c) begin
                        owner       <= d_gnt_c;
                        last_grant  <= d_gnt_c;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= d_gnt_c && bus.d_we;
                        mem_addr_q  <= d_gnt_c ? bus.d_addr : bus.if_addr;
                        mem_wdata_q <= d_gnt_c ? bus.d_wdata : 64'd0;
                        cnt         <= CNT_W'(MEM_LAT - 1);
                        busy_q      <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Last access cycle: the memory output is valid at this edge.
                        if (mem_we_q) begin
                            d_rdata_q <= 64'd0;
                        end else if (owner == OWN_DATA) begin
                            d_rdata_q <= bus.mem_rdata;
                        end else begin
                            if_rdata_q <= bus.mem_rdata[31:0];
                        end
                        if_rvalid_q <= (owner == OWN_FETCH);
                        d_rvalid_q  <= (owner == OWN_DATA);
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if_rvalid_q <= 1'b0;
                    d_rvalid_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) share one stimulus source,
// a byte memory model, and a cycle-level transaction reference model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic sel;  // 0 drives the MEM_LAT=1 instance, 1 the MEM_LAT=3 instance

  always #5 clk = ~clk;

  logic        if_req;
  logic [63:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;

  mem_port_arbiter_if #(.ADDR_W(64)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(64)) bus_b ();
  logic [1:0] state_a, state_b;
  logic [63:0] rd_a, rd_b;

  mem_port_arbiter #(.ADDR_W(64), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .dbg_state(state_a)
  );
  mem_port_arbiter #(.ADDR_W(64), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .dbg_state(state_b)
  );

  assign bus_a.if_req    = !sel && if_req;
  assign bus_a.if_addr   = if_addr;
  assign bus_a.d_req     = !sel && d_req;
  assign bus_a.d_we      = d_we;
  assign bus_a.d_addr    = d_addr;
  assign bus_a.d_wdata   = d_wdata;
  assign bus_a.mem_rdata = rd_a;
  assign bus_b.if_req    = sel && if_req;
  assign bus_b.if_addr   = if_addr;
  assign bus_b.d_req     = sel && d_req;
  assign bus_b.d_we      = d_we;
  assign bus_b.d_addr    = d_addr;
  assign bus_b.d_wdata   = d_wdata;
  assign bus_b.mem_rdata = rd_b;

  logic        o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid, o_mem_en, o_mem_we, o_busy;
  logic [31:0] o_if_rdata;
  logic [63:0] o_d_rdata, o_mem_addr, o_mem_wdata;
  logic [1:0]  o_state;
  assign o_if_gnt    = sel ? bus_b.if_gnt    : bus_a.if_gnt;
  assign o_if_rvalid = sel ? bus_b.if_rvalid : bus_a.if_rvalid;
  assign o_if_rdata  = sel ? bus_b.if_rdata  : bus_a.if_rdata;
  assign o_d_gnt     = sel ? bus_b.d_gnt     : bus_a.d_gnt;
  assign o_d_rvalid  = sel ? bus_b.d_rvalid  : bus_a.d_rvalid;
  assign o_d_rdata   = sel ? bus_b.d_rdata   : bus_a.d_rdata;
  assign o_mem_en    = sel ? bus_b.mem_en    : bus_a.mem_en;
  assign o_mem_we    = sel ? bus_b.mem_we    : bus_a.mem_we;
  assign o_mem_addr  = sel ? bus_b.mem_addr  : bus_a.mem_addr;
  assign o_mem_wdata = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
  assign o_busy      = sel ? bus_b.busy      : bus_a.busy;
  assign o_state     = sel ? state_b         : state_a;

  // ---------------- memories: DUT-side array and reference array ----------------
  logic [7:0] mem_bytes [logic [63:0]];
  logic [7:0] ref_bytes [logic [63:0]];

  function automatic logic [63:0] read8(input logic [63:0] a, input bit use_ref);
    logic [63:0] v;
    logic [63:0] ai;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      ai = a + 64'(i);
      if (use_ref) begin
        if (ref_bytes.exists(ai)) v[8*i +: 8] = ref_bytes[ai];
      end else begin
        if (mem_bytes.exists(ai)) v[8*i +: 8] = mem_bytes[ai];
      end
    end
    return v;
  endfunction

  task automatic write8(input logic [63:0] a, input logic [63:0] v, input bit use_ref);
    for (int i = 0; i < 8; i++) begin
      if (use_ref) ref_bytes[a + 64'(i)] = v[8*i +: 8];
      else         mem_bytes[a + 64'(i)] = v[8*i +: 8];
    end
  endtask

  task automatic preload(input logic [63:0] a, input logic [63:0] v);
    write8(a, v, 1'b0);
    write8(a, v, 1'b1);
  endtask

  // Memory answers for the address driven this cycle, ready before the next edge.
  always @(negedge clk) begin
    rd_a <= read8(bus_a.mem_addr, 1'b0);
    rd_b <= read8(bus_b.mem_addr, 1'b0);
  end

  always @(posedge clk) begin
    if (bus_a.mem_en && bus_a.mem_we) write8(bus_a.mem_addr, bus_a.mem_wdata, 1'b0);
    if (bus_b.mem_en && bus_b.mem_we) write8(bus_b.mem_addr, bus_b.mem_wdata, 1'b0);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d, sel %0d)", tag, got, exp, cyc, sel);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_active;
  int          m_gcyc;
  bit          m_owner;     // 1 = data
  bit          m_we;
  bit          m_last;      // 1 = data was served last
  logic [63:0] m_addr, m_wdata, m_rd;
  logic [31:0] e_if_rdata;
  logic [63:0] e_d_rdata;
  bit          gnt_if_seen, gnt_d_seen;
  logic [63:0] exp_q[$];    // expected response payloads in issue order

  always @(negedge clk) begin
    int  lat;
    bit  in_acc, in_resp, e_if_gnt, e_d_gnt;
    lat = sel ? 3 : 1;
    if (reset) begin
      check("rst_mem_en", 64'(o_mem_en), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_if_gnt", 64'(o_if_gnt), 64'd0);
      check("rst_d_gnt", 64'(o_d_gnt), 64'd0);
      check("rst_if_rvalid", 64'(o_if_rvalid), 64'd0);
      check("rst_d_rvalid", 64'(o_d_rvalid), 64'd0);
      check("rst_if_rdata", 64'(o_if_rdata), 64'd0);
      check("rst_d_rdata", o_d_rdata, 64'd0);
      check("rst_mem_addr", o_mem_addr, 64'd0);
      check("rst_state_idle", 64'(o_state), 64'd0);
      m_active = 0;
      m_last = 1;
      e_if_rdata = '0;
      e_d_rdata = '0;
      gnt_if_seen = 0;
      gnt_d_seen = 0;
      exp_q.delete();
    end else begin
      cyc++;
      if (m_active && cyc > m_gcyc + lat + 1) m_active = 0;
      in_acc  = m_active && cyc > m_gcyc && cyc <= m_gcyc + lat;
      in_resp = m_active && cyc == m_gcyc + lat + 1;
      if (in_resp) begin
        if (exp_q.size() == 0) begin
          check("resp_queue_empty", 64'd1, 64'd0);
        end else if (m_owner) begin
          e_d_rdata = exp_q.pop_front();
        end else begin
          e_if_rdata = exp_q.pop_front()[31:0];
        end
      end
      check("mem_en", 64'(o_mem_en), 64'(in_acc));
      check("mem_we", 64'(o_mem_we), 64'(in_acc && m_we));
      check("mem_addr", o_mem_addr, in_acc ? m_addr : 64'd0);
      check("mem_wdata", o_mem_wdata, in_acc ? m_wdata : 64'd0);
      check("busy", 64'(o_busy), 64'(in_acc || in_resp));
      check("if_rvalid", 64'(o_if_rvalid), 64'(in_resp && !m_owner));
      check("d_rvalid", 64'(o_d_rvalid), 64'(in_resp && m_owner));
      check("if_rdata", 64'(o_if_rdata), 64'(e_if_rdata));
      check("d_rdata", o_d_rdata, e_d_rdata);

      e_if_gnt = 0;
      e_d_gnt = 0;
      if (!m_active) begin
        if (if_req && d_req) begin
          e_if_gnt = m_last;
          e_d_gnt = !m_last;
        end else begin
          e_if_gnt = if_req;
          e_d_gnt = d_req;
        end
      end
      check("if_gnt", 64'(o_if_gnt), 64'(e_if_gnt));
      check("d_gnt", 64'(o_d_gnt), 64'(e_d_gnt));
      gnt_if_seen = o_if_gnt;
      gnt_d_seen = o_d_gnt;

      if (e_if_gnt || e_d_gnt) begin
        m_active = 1;
        m_gcyc = cyc;
        m_owner = e_d_gnt;
        m_last = e_d_gnt;
        m_we = e_d_gnt && d_we;
        m_addr = e_d_gnt ? d_addr : if_addr;
        m_wdata = e_d_gnt ? d_wdata : 64'd0;
        m_rd = read8(m_addr, 1'b1);
        if (m_we) begin
          write8(m_addr, d_wdata, 1'b1);
          exp_q.push_back(64'd0);
        end else begin
          exp_q.push_back(m_rd);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input bit s);
    reset = 1'b1;
    if_req = 1'b0;
    d_req = 1'b0;
    sel = s;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_fetch(input logic [63:0] addr);
    bit got;
    got = 0;
    if_req = 1'b1;
    if_addr = addr;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = gnt_if_seen;
    end
    if (!got) check("fetch_gnt_timeout", 64'd0, 64'd1);
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    bit got;
    got = 0;
    d_req = 1'b1;
    d_we = we;
    d_addr = addr;
    d_wdata = wdata;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = gnt_d_seen;
    end
    if (!got) check("data_gnt_timeout", 64'd0, 64'd1);
    d_req = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if (if_req && gnt_if_seen) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = 64'h6000 + 64'($urandom_range(0, 63));
      end else if (!if_req) begin
        if_req = ($urandom_range(0, 2) == 0);
        if_addr = 64'h6000 + 64'($urandom_range(0, 63));
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (d_req && gnt_d_seen || !d_req) begin
        d_req = (d_req && gnt_d_seen) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = 64'h6000 + 64'($urandom_range(0, 63));
        d_wdata = {$urandom, $urandom};
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
      tick();
    end
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    reset = 1'b1;
    sel = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    preload(64'h2000, 64'h0000_0000_8A00_0000);
    preload(64'h4000, 64'hCAFE_F00D_DEAD_BEEF);
    preload(64'h5000, 64'h0123_4567_89AB_CDEF);
    tick();
    tick();
    reset = 1'b0;

    // fetch with MEM_LAT=1
    do_fetch(64'h2000);
    repeat (3) tick();
    // store then load back
    do_data(1'b1, 64'h3000, 64'h1122_3344_5566_7788);
    repeat (3) tick();
    do_data(1'b0, 64'h3000, 64'h0);
    repeat (3) tick();
    // address changes right after the handshake
    do_data(1'b0, 64'h4000, 64'h0);
    d_addr = 64'h5000;
    repeat (3) tick();

    // both requesters held from reset
    reset = 1'b1;
    if_req = 1'b1;
    if_addr = 64'h2000;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 64'h3000;
    tick();
    tick();
    reset = 1'b0;
    repeat (13) tick();
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (4) tick();
    random_phase(300);

    // MEM_LAT=3 instance
    apply_reset(1'b1);
    do_data(1'b0, 64'h4000, 64'h0);
    d_addr = 64'h5000;
    repeat (6) tick();
    // reset during the second access cycle of a store
    do_data(1'b1, 64'h3100, 64'hA5A5_5A5A_0F0F_F0F0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_fetch(64'h2000);
    repeat (6) tick();
    random_phase(300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
